vga_sync_gen: RTL and testbench

- Timing source for the video path: generates hsync/vsync, the pixel-rate strobe, a visible-area flag and the current pixel coordinates pix_x/pix_y.
- The text-overlay and graphics generators consume pix_x/pix_y and return rgb.
- Sits between the board clock and the VGA connector; the top-level registers the returned rgb on p_tick.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_pix_div.sv | 31 +++
 rtl/vga_sync_gen.sv | 100 ++++++++++
 tb/tb_vga_sync_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Purpose: shared 640x480@60 timing constants, coordinate type and sync polarity for the video path.
// Latency: n/a (constants only).
// Backpressure: n/a; the sync generator, text overlay and graphics blocks all import this package.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Both syncs are active-low pulses for 640x480@60.
    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int VGA_CLK_DIV   = 2;
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/vga_pix_div.sv
// Purpose: pixel-rate divider; p_tick pulses for one clk every CLK_DIV clks.
// Latency: first p_tick CLK_DIV-1 edges after reset release (constantly high when CLK_DIV=1).
// Backpressure: none; free-running.
// Ports: clk, reset (async active-low), p_tick (decode of the last divider count).
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (p_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // With CLK_DIV=1 div_cnt is pinned at 0, so p_tick is high even in reset.
    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: VGA timing source - hsync/vsync, pixel strobe, visible flag and pix_x/pix_y coordinates.
// Latency: syncs and video_on are registered from the next coordinates, so zero skew against pix_x/pix_y.
// Backpressure: none; free-running, all outputs held for a full pixel period.
// Ports: clk, reset (async active-low); hsync, vsync, video_on, p_tick, pix_x, pix_y, frame_start;
//        frame_cnt[15:0] only when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic [15:0]        frame_cnt,
`endif
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W) || CLK_DIV < 1) begin : g_bad_cfg
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t next_x;
    coord_t next_y;
    logic   h_wrap;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        h_wrap = (pix_x == H_LAST);
        next_x = h_wrap ? '0 : pix_x + coord_t'(1);
        next_y = pix_y;
        if (h_wrap) begin
            next_y = (pix_y == V_LAST) ? '0 : pix_y + coord_t'(1);
        end
    end

    // Decodes use next_x/next_y so they land on the same edge as the coordinates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_x    <= H_LAST;
            pix_y    <= V_LAST;
            hsync    <= ~SYNC_ACTIVE;
            vsync    <= ~SYNC_ACTIVE;
            video_on <= 1'b0;
        end else if (p_tick) begin
            pix_x    <= next_x;
            pix_y    <= next_y;
            hsync    <= (next_x >= HS_FIRST && next_x <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync    <= (next_y >= VS_FIRST && next_y <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on <= (next_x < H_VIS) && (next_y < V_VIS);
        end
    end

    // High for the single clk whose edge moves the raster to (0,0).
    assign frame_start = p_tick && (pix_x == H_LAST) && (pix_y == V_LAST);

`ifdef VGA_SYNC_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: self-checking bench for vga_sync_gen (standard 640x480, CLK_DIV=1, and a tiny raster for frame-level runs).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync_gen;

    logic clk;
    logic rst_a;
    logic rst_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard 640x480, CLK_DIV=2
    logic s_hs, s_vs, s_von, s_pt, s_fs;
    logic [9:0] s_x, s_y;
    // Standard geometry, CLK_DIV=1
    logic d_hs, d_vs, d_von, d_pt, d_fs;
    logic [9:0] d_x, d_y;
    // Tiny raster: H 8/2/3/3 = 16, V 6/2/2/2 = 12, CLK_DIV=2
    logic m_hs, m_vs, m_von, m_pt, m_fs;
    logic [9:0] m_x, m_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] s_fc, d_fc, m_fc;
`endif

    vga_sync_gen u_std (
        .clk(clk), .reset(rst_a), .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .p_tick(s_pt),
        .pix_x(s_x), .pix_y(s_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_cnt(s_fc),
`endif
        .frame_start(s_fs)
    );

    vga_sync_gen #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .reset(rst_a), .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .p_tick(d_pt),
        .pix_x(d_x), .pix_y(d_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_cnt(d_fc),
`endif
        .frame_start(d_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .reset(rst_b), .hsync(m_hs), .vsync(m_vs), .video_on(m_von), .p_tick(m_pt),
        .pix_x(m_x), .pix_y(m_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_cnt(m_fc),
`endif
        .frame_start(m_fs)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int   k;      // posedges since reset release
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
        logic pt;
        logic fs;
        int   dx;     // CLK_DIV=1 instance, -1 = not checked
        int   dy;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int cur;
        int hs_low, von_hi, vs_low, fs_cnt, first_fs, last_fs, von_bad, hs_bad, pt_bad;
        bit found;

        vecs[0]  = '{1,    799, 524, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0,   0};
        vecs[1]  = '{2,    0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1,   0};
        vecs[2]  = '{3,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1};
        vecs[3]  = '{800,  399, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 799, 0};
        vecs[4]  = '{801,  399, 0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0,   1};
        vecs[5]  = '{1280, 639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1};
        vecs[6]  = '{1282, 640, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1};
        vecs[7]  = '{1312, 655, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1};
        vecs[8]  = '{1314, 656, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1};
        vecs[9]  = '{1504, 751, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1};
        vecs[10] = '{1506, 752, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1};
        vecs[11] = '{1600, 799, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1};
        vecs[12] = '{1601, 799, 0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1};
        vecs[13] = '{1602, 0,   1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1,   2};
        vecs[14] = '{1603, 0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2,   2};

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        // ---- reset state ----
        chk("rst_x",  int'(s_x), 799);
        chk("rst_y",  int'(s_y), 524);
        chk("rst_hs", int'(s_hs), 1);
        chk("rst_vs", int'(s_vs), 1);
        chk("rst_von", int'(s_von), 0);
        chk("rst_pt", int'(s_pt), 0);
        chk("rst_fs", int'(s_fs), 0);
        chk("rst_div1_pt", int'(d_pt), 1);
        chk("rst_div1_x", int'(d_x), 799);
        chk("rst_small_x", int'(m_x), 15);
        chk("rst_small_y", int'(m_y), 11);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("rst_fc", int'(s_fc), 0);
`endif

        // ---- release and walk the table ----
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        cur = 0;
        chk("rel_std_pt", int'(s_pt), 0);
        chk("rel_div1_fs", int'(d_fs), 1);
        for (int i = 0; i < 15; i++) begin
            while (cur < vecs[i].k) begin
                @(negedge clk);
                cur++;
            end
            #1;
            chk($sformatf("v%0d_x", i),   int'(s_x),   vecs[i].x);
            chk($sformatf("v%0d_y", i),   int'(s_y),   vecs[i].y);
            chk($sformatf("v%0d_hs", i),  int'(s_hs),  int'(vecs[i].hs));
            chk($sformatf("v%0d_vs", i),  int'(s_vs),  int'(vecs[i].vs));
            chk($sformatf("v%0d_von", i), int'(s_von), int'(vecs[i].von));
            chk($sformatf("v%0d_pt", i),  int'(s_pt),  int'(vecs[i].pt));
            chk($sformatf("v%0d_fs", i),  int'(s_fs),  int'(vecs[i].fs));
            if (vecs[i].dx >= 0) begin
                chk($sformatf("v%0d_div1_x", i),  int'(d_x),  vecs[i].dx);
                chk($sformatf("v%0d_div1_y", i),  int'(d_y),  vecs[i].dy);
                chk($sformatf("v%0d_div1_pt", i), int'(d_pt), 1);
            end
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("std_fc_after_first_frame", int'(s_fc), 1);
        chk("div1_fc_after_first_frame", int'(d_fc), 1);
`endif

        // ---- one full line (line 1) on the standard raster, clk-level counts ----
        hs_low = 0;
        von_hi = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            #1;
            if (!s_hs) hs_low++;
            if (s_von) von_hi++;
        end
        chk("line_hs_low_clks", hs_low, 192);
        chk("line_von_clks", von_hi, 1280);

        // ---- tiny raster: two full frames ----
        @(negedge clk);
        rst_b = 1'b1;
        vs_low = 0; hs_low = 0; von_hi = 0; fs_cnt = 0;
        first_fs = -1; last_fs = -1; von_bad = 0; hs_bad = 0; pt_bad = 0;
        for (int k = 1; k <= 770; k++) begin
            @(negedge clk);
            #1;
            if (!m_vs) vs_low++;
            if (!m_hs) hs_low++;
            if (m_von) von_hi++;
            if (m_von && (m_x >= 10'd8 || m_y >= 10'd6)) von_bad++;
            if (!m_hs && (m_x < 10'd10 || m_x > 10'd12)) hs_bad++;
            if (m_pt != (k % 2 == 1)) pt_bad++;
            if (m_fs) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = k;
                else chk("small_frame_period", k - last_fs, 384);
                last_fs = k;
            end
`ifdef VGA_SYNC_FRAME_CNT_EN
            if (k == 385) chk("small_fc_k385", int'(m_fc), 1);
            if (k == 386) chk("small_fc_k386", int'(m_fc), 2);
`endif
        end
        chk("small_fs_count", fs_cnt, 3);
        chk("small_first_fs_k", first_fs, 1);
        chk("small_vs_low_clks", vs_low, 128);
        chk("small_hs_low_clks", hs_low, 144);
        chk("small_von_clks", von_hi, 193);
        chk("small_von_outside", von_bad, 0);
        chk("small_hs_outside", hs_bad, 0);
        chk("small_pt_pattern", pt_bad, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("small_fc_3_frames", int'(m_fc), 3);
`endif

        // ---- asynchronous reset mid-frame at (5,3) ----
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            #1;
            if (m_x == 10'd5 && m_y == 10'd3) found = 1'b1;
        end
        chk("find_midframe", int'(found), 1);
        #1;
        rst_b = 1'b0;
        #1;
        chk("arst_x", int'(m_x), 15);
        chk("arst_y", int'(m_y), 11);
        chk("arst_hs", int'(m_hs), 1);
        chk("arst_vs", int'(m_vs), 1);
        chk("arst_von", int'(m_von), 0);
        chk("arst_pt", int'(m_pt), 0);
        chk("arst_fs", int'(m_fs), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("arst_fc", int'(m_fc), 0);
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("arst_hold_x", int'(m_x), 15);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("rerel_k0_pt", int'(m_pt), 0);
        @(negedge clk);
        #1;
        chk("rerel_k1_pt", int'(m_pt), 1);
        chk("rerel_k1_fs", int'(m_fs), 1);
        chk("rerel_k1_x", int'(m_x), 15);
        @(negedge clk);
        #1;
        chk("rerel_k2_x", int'(m_x), 0);
        chk("rerel_k2_y", int'(m_y), 0);
        chk("rerel_k2_von", int'(m_von), 1);
        chk("rerel_k2_pt", int'(m_pt), 0);
        chk("rerel_k2_fs", int'(m_fs), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("rerel_k2_fc", int'(m_fc), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
